// File: rtl/cmd_controller_p_pkg.sv
// Shared decode constants and state encodings for the command controller.
// Header fields sit in the low byte; the header flag is the word MSB.
package cmd_pkg;

  localparam logic [3:0] OP_LOAD_KEY  = 4'd0;
  localparam logic [3:0] OP_LOAD_BLK  = 4'd1;
  localparam logic [3:0] OP_START     = 4'd2;
  localparam logic [3:0] OP_READ_CFG  = 4'd3;
  localparam logic [3:0] OP_WRITE_CFG = 4'd7;

  localparam int OP_LSB  = 0;
  localparam int OP_MSB  = 3;
  localparam int IDX_LSB = 4;
  localparam int IDX_MSB = 7;

  // Header flag position depends on the word width of the instance.
  function automatic int hdr_bit(input int word_w);
    return word_w - 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    PL_KEY,
    PL_BLK,
    PL_CFG
  } pl_t;

endpackage

// File: rtl/cmd_shadow_buf.sv
// Word-serial fill buffer for multi-word payloads. fill_flat already includes
// the word being pushed this cycle so the owner can commit on the last push.
module cmd_shadow_buf #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    init,
  input  logic [3:0]              last_idx,
  input  logic                    push,
  input  logic [WORD_W-1:0]       din,
  output logic [DEPTH*WORD_W-1:0] fill_flat,
  output logic                    last
);

  logic [3:0]        cnt_reg;
  logic [3:0]        last_idx_reg;
  logic [WORD_W-1:0] buf_mem [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_reg      <= '0;
      last_idx_reg <= '0;
      for (int i = 0; i < DEPTH; i++) buf_mem[i] <= '0;
    end else if (init) begin
      cnt_reg      <= '0;
      last_idx_reg <= last_idx;
    end else if (push) begin
      cnt_reg <= cnt_reg + 4'd1;
      for (int i = 0; i < DEPTH; i++)
        if (cnt_reg == 4'(i)) buf_mem[i] <= din;
    end
  end

  assign last = (cnt_reg == last_idx_reg);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fill
    assign fill_flat[gi*WORD_W +: WORD_W] = (push && cnt_reg == 4'(gi)) ? din : buf_mem[gi];
  end

endmodule

// File: rtl/cmd_controller_p.sv
// Command front-end: decodes headers, gathers payloads through a shadow
// buffer, commits atomically, pulses engine start and answers config reads.
module cmd_controller_p
  import cmd_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int KEY_WORDS = 4,
  parameter int BLK_WORDS = 4,
  parameter int NUM_CH    = 2,
  parameter int CFG_REGS  = 8
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [WORD_W-1:0]                   in_word,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [WORD_W-1:0]                   out_word,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_CH*KEY_WORDS*WORD_W-1:0]  key_flat,
  output logic [NUM_CH-1:0]                   key_valid,
  output logic [BLK_WORDS*WORD_W-1:0]         blk_flat,
  output logic                                blk_valid,
  output logic                                start,
  output logic [3:0]                          start_ch,
  output logic [CFG_REGS*WORD_W-1:0]          cfg_flat,
  output logic                                err
);

  localparam int         DEPTH      = (KEY_WORDS > BLK_WORDS) ? KEY_WORDS : BLK_WORDS;
  localparam int         HDR        = hdr_bit(WORD_W);
  localparam logic [4:0] NUM_CH_L   = 5'(NUM_CH);
  localparam logic [4:0] CFG_REGS_L = 5'(CFG_REGS);
  localparam logic [3:0] KEY_LAST   = 4'(KEY_WORDS - 1);
  localparam logic [3:0] BLK_LAST   = 4'(BLK_WORDS - 1);

  state_t state_reg, state_next;
  pl_t    pl_kind_reg, pl_kind_next;
  logic   discard_reg, discard_next;
  logic [3:0] pl_idx_reg;
  logic   ready_en_reg;

  logic [KEY_WORDS*WORD_W-1:0] key_mem [NUM_CH];
  logic [NUM_CH-1:0]           key_valid_reg;
  logic [BLK_WORDS*WORD_W-1:0] blk_reg;
  logic                        blk_valid_reg;
  logic [WORD_W-1:0]           cfg_mem [CFG_REGS];
  logic                        start_reg, start_next;
  logic [3:0]                  start_ch_reg;
  logic                        err_reg, err_next;
  logic [WORD_W-1:0]           out_word_reg, cfg_rd;
  logic                        out_valid_reg;

  logic       accept, is_hdr, ch_ok, cfg_ok, push;
  logic [3:0] op, idx;
  logic       buf_init, buf_last, commit, resp_load, resp_done;
  logic [3:0] buf_last_idx;
  logic [DEPTH*WORD_W-1:0] fill_flat;

  assign in_ready = ready_en_reg && (state_reg != ST_RESP);
  assign accept   = in_valid && in_ready;
  assign is_hdr   = in_word[HDR];
  assign op       = in_word[OP_MSB:OP_LSB];
  assign idx      = in_word[IDX_MSB:IDX_LSB];
  assign ch_ok    = {1'b0, idx} < NUM_CH_L;
  assign cfg_ok   = {1'b0, idx} < CFG_REGS_L;
  assign push     = (state_reg == ST_PAYLOAD) && accept;

  cmd_shadow_buf #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_shadow (
    .clock     (clock),
    .reset     (reset),
    .init      (buf_init),
    .last_idx  (buf_last_idx),
    .push      (push),
    .din       (in_word),
    .fill_flat (fill_flat),
    .last      (buf_last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      pl_kind_reg  <= PL_KEY;
      discard_reg  <= 1'b0;
      pl_idx_reg   <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pl_kind_reg  <= pl_kind_next;
      discard_reg  <= discard_next;
      if (buf_init) pl_idx_reg <= idx;
      ready_en_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pl_kind_next = pl_kind_reg;
    discard_next = discard_reg;
    buf_init     = 1'b0;
    buf_last_idx = '0;
    start_next   = 1'b0;
    err_next     = 1'b0;
    commit       = 1'b0;
    resp_load    = 1'b0;
    resp_done    = 1'b0;
    case (state_reg)
      ST_IDLE: if (accept) begin
        if (!is_hdr) begin
          err_next = 1'b1;
        end else begin
          case (op)
            OP_LOAD_KEY: begin
              buf_init = 1'b1; buf_last_idx = KEY_LAST; pl_kind_next = PL_KEY;
              discard_next = !ch_ok; err_next = !ch_ok; state_next = ST_PAYLOAD;
            end
            OP_LOAD_BLK: begin
              buf_init = 1'b1; buf_last_idx = BLK_LAST; pl_kind_next = PL_BLK;
              discard_next = 1'b0; state_next = ST_PAYLOAD;
            end
            OP_START: begin
              start_next = ch_ok; err_next = !ch_ok;
            end
            OP_READ_CFG: begin
              resp_load = cfg_ok; err_next = !cfg_ok;
              if (cfg_ok) state_next = ST_RESP;
            end
            OP_WRITE_CFG: begin
              buf_init = 1'b1; buf_last_idx = 4'd0; pl_kind_next = PL_CFG;
              discard_next = !cfg_ok; err_next = !cfg_ok; state_next = ST_PAYLOAD;
            end
            default: err_next = 1'b1;
          endcase
        end
      end
      ST_PAYLOAD: if (accept && buf_last) begin
        commit     = !discard_reg;
        state_next = ST_IDLE;
      end
      ST_RESP: if (out_valid_reg && out_ready) begin
        resp_done  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_rd = '0;
    for (int i = 0; i < CFG_REGS; i++)
      if (idx == 4'(i)) cfg_rd = cfg_mem[i];
  end

  // Committed state only moves on the accept of the final payload word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) key_mem[c] <= '0;
      for (int r = 0; r < CFG_REGS; r++) cfg_mem[r] <= '0;
      key_valid_reg <= '0;
      blk_reg       <= '0;
      blk_valid_reg <= 1'b0;
      start_reg     <= 1'b0;
      start_ch_reg  <= '0;
      err_reg       <= 1'b0;
      out_word_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      start_reg    <= start_next;
      start_ch_reg <= start_next ? idx : 4'd0;
      err_reg      <= err_next;
      for (int c = 0; c < NUM_CH; c++)
        if (commit && pl_kind_reg == PL_KEY && pl_idx_reg == 4'(c)) begin
          key_mem[c]       <= fill_flat[KEY_WORDS*WORD_W-1:0];
          key_valid_reg[c] <= 1'b1;
        end
      for (int r = 0; r < CFG_REGS; r++)
        if (commit && pl_kind_reg == PL_CFG && pl_idx_reg == 4'(r))
          cfg_mem[r] <= fill_flat[WORD_W-1:0];
      if (commit && pl_kind_reg == PL_BLK) begin
        blk_reg       <= fill_flat[BLK_WORDS*WORD_W-1:0];
        blk_valid_reg <= 1'b1;
      end else if (start_next) begin
        blk_valid_reg <= 1'b0;
      end
      if (resp_load) begin
        out_word_reg  <= cfg_rd;
        out_valid_reg <= 1'b1;
      end else if (resp_done) begin
        out_word_reg  <= '0;
        out_valid_reg <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_key
    assign key_flat[gi*KEY_WORDS*WORD_W +: KEY_WORDS*WORD_W] = key_mem[gi];
  end

  for (genvar gi = 0; gi < CFG_REGS; gi++) begin : g_cfg
    assign cfg_flat[gi*WORD_W +: WORD_W] = cfg_mem[gi];
  end

  assign key_valid = key_valid_reg;
  assign blk_flat  = blk_reg;
  assign blk_valid = blk_valid_reg;
  assign start     = start_reg;
  assign start_ch  = start_ch_reg;
  assign err       = err_reg;
  assign out_word  = out_word_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_cmd_controller_p.sv
// Directed-vector bench for cmd_controller_p with default parameters.
// Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
module tb_cmd_controller_p;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  in_word = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  out_word;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [255:0] key_flat;
  logic [1:0]   key_valid;
  logic [127:0] blk_flat;
  logic         blk_valid;
  logic         start;
  logic [3:0]   start_ch;
  logic [255:0] cfg_flat;
  logic         err;

  int n_vec = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int err_base;

  cmd_controller_p dut (
    .clock     (clock),
    .reset     (reset),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .key_flat  (key_flat),
    .key_valid (key_valid),
    .blk_flat  (blk_flat),
    .blk_valid (blk_valid),
    .start     (start),
    .start_ch  (start_ch),
    .cfg_flat  (cfg_flat),
    .err       (err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (err) err_cnt++;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] w);
    int t;
    @(negedge clock);
    in_word  = w;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clock);
      t++;
    end
    if (!in_ready) check("ready_timeout", 256'(in_ready), 256'(1));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    idle(2);
    check("rst_in_ready", 256'(in_ready), 256'(0));
    check("rst_key_valid", 256'(key_valid), 256'(0));
    check("rst_outs", 256'({out_valid, blk_valid, start, err, start_ch}), 256'(0));
    @(negedge clock);
    reset = 1'b0;
    idle(1);
    check("ready_after_rst", 256'(in_ready), 256'(1));

    // key load on channel 0
    send(32'h80000000);
    send(32'he0318a99); check("kv_w0", 256'(key_valid), 256'(0));
    send(32'h23f247b3); check("kv_w1", 256'(key_valid), 256'(0));
    send(32'hed8ff212); check("kv_w2", 256'(key_valid), 256'(0));
    send(32'hef0bc156);
    check("kv_commit", 256'(key_valid), 256'(1));
    check("key0", 256'(key_flat[127:0]), 256'(128'hef0bc156_ed8ff212_23f247b3_e0318a99));

    // config write then read with back-pressure
    send(32'h80000007);
    send(32'h00000004);
    check("cfg0", 256'(cfg_flat[31:0]), 256'(32'h4));
    send(32'h80000003);
    check("rd_valid", 256'(out_valid), 256'(1));
    check("rd_word", 256'(out_word), 256'(32'h4));
    check("rd_busy", 256'(in_ready), 256'(0));
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("rd_hold", 256'({in_ready, out_valid, out_word}), 256'({1'b0, 1'b1, 32'h4}));
    end
    @(negedge clock);
    out_ready = 1'b1;
    idle(1);
    check("rd_done", 256'({in_ready, out_valid}), 256'({1'b1, 1'b0}));
    out_ready = 1'b0;

    // start pulses
    send(32'h80000012);
    check("start_ch1", 256'({start, start_ch, err}), 256'({1'b1, 4'd1, 1'b0}));
    idle(1);
    check("start_1cyc", 256'(start), 256'(0));
    send(32'h80000032);
    check("start_bad", 256'({start, err}), 256'({1'b0, 1'b1}));
    idle(1);
    check("err_1cyc", 256'(err), 256'(0));

    // bad channel key load consumes but discards its payload
    send(32'h80000030);
    check("key_bad_err", 256'(err), 256'(1));
    for (int i = 0; i < 4; i++) begin
      send(32'h80000012);
      check("discard_nostart", 256'({start, err}), 256'(0));
    end
    check("discard_kv", 256'(key_valid), 256'(1));
    send(32'h80000012);
    check("back_idle", 256'(start), 256'(1));

    // block of MSB-set words with gaps: all payload, no errors
    err_base = err_cnt;
    send(32'h80000001);
    idle(2); send(32'h80000000);
    send(32'h80000011);
    idle(3); send(32'h800000a2);
    check("blk_pending", 256'(blk_valid), 256'(0));
    idle(1); send(32'h8000ffff);
    check("blk_valid", 256'(blk_valid), 256'(1));
    check("blk_data", 256'(blk_flat), 256'(128'h8000ffff_800000a2_80000011_80000000));
    check("blk_noerr", 256'(err_cnt - err_base), 256'(0));
    check("blk_nostart", 256'(start), 256'(0));
    send(32'h80000002);
    check("start_clr_blk", 256'({start, start_ch, blk_valid}), 256'({1'b1, 4'd0, 1'b0}));

    // non-header and unknown opcode
    err_base = err_cnt;
    send(32'h12345678);
    check("nonhdr_err", 256'({err, in_ready}), 256'({1'b1, 1'b1}));
    send(32'h8000000a);
    check("badop_err", 256'({err, in_ready}), 256'({1'b1, 1'b1}));
    idle(1);
    check("err_pulses", 256'(err_cnt - err_base), 256'(2));
    send(32'h80000012);
    check("idle_after_err", 256'(start), 256'(1));

    // asynchronous reset mid-payload
    send(32'h80000000);
    send(32'h11111111);
    send(32'h22222222);
    #2;
    reset = 1'b1;
    #1;
    check("arst_key", 256'({key_valid, key_flat[127:0]}), 256'(0));
    check("arst_cfg", 256'(cfg_flat), 256'(0));
    check("arst_ready", 256'(in_ready), 256'(0));
    @(negedge clock);
    reset = 1'b0;
    idle(1);
    check("arst_ready1", 256'(in_ready), 256'(1));
    send(32'h80000010);
    send(32'h0000000a); send(32'h0000000b); send(32'h0000000c); send(32'h0000000d);
    check("reload_kv", 256'(key_valid), 256'(2'b10));
    check("reload_key", 256'(key_flat), {32'hd, 32'hc, 32'hb, 32'ha, 128'h0});

    // reloading a valid key keeps the old one until the new commit
    send(32'h80000010);
    send(32'h00000001); send(32'h00000002);
    check("old_key_held", 256'({key_valid, key_flat[255:128]}), 256'({2'b10, 32'hd, 32'hc, 32'hb, 32'ha}));
    send(32'h00000003); send(32'h00000004);
    check("new_key", 256'(key_flat[255:128]), 256'(128'h4_00000003_00000002_00000001));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
